child_dispatch: RTL and testbench
=================================

# child_dispatch

Parent-to-child scatter block for the multicore processor. The parent core writes `{target core, 32-bit word}` commands. The block queues them in a small FIFO and delivers each one into a per-child mailbox register. Each child consumes its mailbox with a valid/ack handshake. Address 31 broadcasts one word to every child at once. This is the outbound counterpart of the child-to-parent `buf_val`/`buf_flag` gather path.

## Interface
Parameters:
- `NUM_CORES`, 31: number of child mailboxes; must be ≤ 31.
- `DATA_W`, 32: mailbox word width.
- `FIFO_DEPTH`, 4: command FIFO entries; must be a power of two.

Ports:
- `Clk`  in  1  system clock; all state changes on the rising edge.
- `Reset`  in  1  asynchronous, active-low reset.
- `par_wr_en`  in  1  parent write strobe, one command per cycle.
- `par_wr_addr`  in  5  target child index; 5'd31 = broadcast.
- `par_wr_data`  in  DATA_W  command word.
- `par_full`  out  1  FIFO full; a write presented while high is dropped.
- `par_all_taken`  out  1  FIFO empty and no child mailbox valid.
- `drop_count`  out  8  saturating count of dropped commands.
- `child_data`  out  NUM_CORES*DATA_W  flattened mailboxes; child i occupies bits [i*DATA_W +: DATA_W].
- `child_valid`  out  NUM_CORES  mailbox i holds an unconsumed word.
- `child_ack`  in  NUM_CORES  child i consumes its mailbox.

## Operation
- **Write path.** A command is accepted when `par_wr_en` is high, `par_full` is low, and the address is valid. A valid address is `< NUM_CORES` or equal to 31.
- **Drops.** A command is dropped when the FIFO is full or the address is in [NUM_CORES, 30]. Each drop increments `drop_count`, which saturates at 255.
- **Full at write time.** The full check uses `par_full` as sampled that cycle. A pop in the same cycle does not rescue the write.
- **Dispatch FSM.** The state is recomputed every cycle from the FIFO head:
  - `S_IDLE`: FIFO empty.
  - `S_UNI`: head is a unicast to child i. If `child_valid[i]` is low, load mailbox i, pop the FIFO, and return to the state implied by the new head. Otherwise stall.
  - `S_BCAST`: head is a broadcast. If every `child_valid` bit is low, load all mailboxes with the word and pop. Otherwise stall.
- **Ordering.** Delivery is strictly in FIFO order. A stalled head blocks later commands, including commands to idle children.
- **Ack.** `child_ack[i]` while `child_valid[i]` is high clears the valid bit at the next edge. An ack while the valid bit is low is ignored.
- **Ack/load interaction.** A mailbox is loaded only when its valid bit is already low, so an ack and a load can never target the same mailbox in the same cycle.
- **Data retention.** `child_data[i]` holds its value after an ack until the next load.
- **`par_all_taken`** = FIFO empty AND no bit of `child_valid` set.

## Timing
- **Reset values.** All of the following are 0 while `Reset` is low:
  - `child_valid`, `child_data`, `drop_count`
  - FIFO pointers
  - FSM state = `S_IDLE`
  - `par_full`
  
  `par_all_taken` is 1 while `Reset` is low.
- **Reset mid-operation.** Queued commands and mailbox contents are discarded immediately. There is no flush handshake.
- **Latency.** A write accepted at edge N is at the FIFO head in cycle N+1. If its mailbox is free, it loads at edge N+1, so `child_valid` is high in cycle N+2. This gives 2-cycle write-to-valid latency.
- **Throughput.** One pop per cycle, so unicasts to distinct free children sustain one delivery per cycle.
- **Ack turnaround.** An ack in cycle M clears valid at edge M. A queued command for the same child loads at edge M+1. The mailbox is therefore busy for at least 1 cycle between words.
- **Status outputs.** `par_full` and `par_all_taken` are registered-state functions with no combinational path from inputs.
- **Simultaneous events.** A write and a pop in the same cycle on a non-full FIFO both take effect, and the count is unchanged.

## Structure
- **Shared package** (alongside the other multicore constants): `NUM_CORES`, `BCAST_ADDR = 5'd31`, `MBOX_W = 32`, and the FSM state encoding `S_IDLE`, `S_UNI`, `S_BCAST`.
- **Sub-module `cmd_fifo`:** a parameterised synchronous FIFO with async active-low reset.
  - Width: 5+DATA_W.
  - Ports: push, pop, full, empty, head.
  - It contains all of the pointer and count logic.
- **Top level:** holds the FSM, the mailbox register array, and the drop counter.

## Test plan
- **Reset.** Assert `Reset`=0 mid-stream with 3 queued commands → `child_valid`=0, `par_all_taken`=1, `drop_count`=0 immediately; no delivery after release.
- **Unicast.** Write (addr 5, 0xDEADBEEF) at edge N → `child_valid[5]`=1 and `child_data[5]`=0xDEADBEEF in cycle N+2. Ack one cycle later → valid=0 next cycle, `par_all_taken`=1.
- **Head blocking.** Write (3, 0x1), then (3, 0x2), then (7, 0x3) with no acks → child 3 holds 0x1 and child 7 stays invalid. Ack child 3 → 0x2 loads next cycle, then 0x3 reaches child 7 one cycle after that.
- **Broadcast.** With child 10 holding an unacked word, write (31, 0xCAFE0000) → no mailbox loads until child 10 is acked. The following cycle, all 31 mailboxes = 0xCAFE0000 and `child_valid`=all ones.
- **Overflow.** With no acks, write 6 commands to child 0 in back-to-back cycles:
  - 1 loads into the mailbox.
  - 4 fill the FIFO; `par_full`=1.
  - 1 is dropped; `drop_count`=1.
  - A write in the same cycle as the first pop is still dropped.
- **Bad address and saturation.** Write addr 30 with `NUM_CORES`=30 → `drop_count`+1 and no mailbox change. Drive 300 bad writes → `drop_count`=255.

Source files
------------

// File: rtl/child_dispatch_pkg.sv
// rtl/child_dispatch_pkg.sv - shared multicore constants and dispatch FSM encoding
package child_dispatch_pkg;

    localparam int         NUM_CORES  = 31;
    localparam logic [4:0] BCAST_ADDR = 5'd31;
    localparam int         MBOX_W     = 32;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_UNI   = 2'd1,
        S_BCAST = 2'd2
    } dispatch_state_e;

endpackage

// File: rtl/cmd_fifo.sv
// rtl/cmd_fifo.sv - synchronous command FIFO with first-word-fall-through head
module cmd_fifo #(
    parameter int WIDTH = 37,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW:0]      count;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == (PW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/child_dispatch.sv
// rtl/child_dispatch.sv - parent-to-child command scatter into per-child mailboxes
module child_dispatch #(
    parameter int NUM_CORES  = child_dispatch_pkg::NUM_CORES,
    parameter int DATA_W     = child_dispatch_pkg::MBOX_W,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        Clk,
    input  logic                        Reset,
    input  logic                        par_wr_en,
    input  logic [4:0]                  par_wr_addr,
    input  logic [DATA_W-1:0]           par_wr_data,
    output logic                        par_full,
    output logic                        par_all_taken,
    output logic [7:0]                  drop_count,
    output logic [NUM_CORES*DATA_W-1:0] child_data,
    output logic [NUM_CORES-1:0]        child_valid,
    input  logic [NUM_CORES-1:0]        child_ack
);

    import child_dispatch_pkg::*;

    localparam int CMD_W = 5 + DATA_W;

    dispatch_state_e     state;
    logic                addr_ok;
    logic                push;
    logic                pop;
    logic                drop;
    logic                fifo_empty;
    logic [CMD_W-1:0]    fifo_head;
    logic [4:0]          head_addr;
    logic [DATA_W-1:0]   head_data;
    logic                head_free;
    logic                any_valid;
    logic [NUM_CORES-1:0] load_vec;
    logic [DATA_W-1:0]   mbox [NUM_CORES];

    assign addr_ok = (par_wr_addr == BCAST_ADDR) || (32'(par_wr_addr) < NUM_CORES);
    assign push    = par_wr_en && !par_full && addr_ok;
    assign drop    = par_wr_en && (par_full || !addr_ok);

    cmd_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_cmd_fifo (
        .clk       (Clk),
        .rst_n     (Reset),
        .push      (push),
        .push_data ({par_wr_addr, par_wr_data}),
        .pop       (pop),
        .full      (par_full),
        .empty     (fifo_empty),
        .head      (fifo_head)
    );

    assign head_addr     = fifo_head[CMD_W-1 -: 5];
    assign head_data     = fifo_head[DATA_W-1:0];
    assign any_valid     = |child_valid;
    assign par_all_taken = fifo_empty && !any_valid;

    // The FIFO already holds registered state, so the dispatch state is a
    // pure decode of its head; this keeps write-to-valid at two cycles.
    always_comb begin
        state = S_IDLE;
        if (!fifo_empty) begin
            state = (head_addr == BCAST_ADDR) ? S_BCAST : S_UNI;
        end
    end

    always_comb begin
        head_free = 1'b0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (head_addr == 5'(i)) head_free = !child_valid[i];
        end
    end

    always_comb begin
        pop      = 1'b0;
        load_vec = '0;
        case (state)
            S_UNI: begin
                if (head_free) begin
                    pop = 1'b1;
                    for (int i = 0; i < NUM_CORES; i++) begin
                        load_vec[i] = (head_addr == 5'(i));
                    end
                end
            end
            S_BCAST: begin
                if (!any_valid) begin
                    pop      = 1'b1;
                    load_vec = '1;
                end
            end
            default: begin
                pop      = 1'b0;
                load_vec = '0;
            end
        endcase
    end

    // Loads only target empty mailboxes, so load and ack never collide.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            child_valid <= '0;
            for (int i = 0; i < NUM_CORES; i++) mbox[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_CORES; i++) begin
                if (load_vec[i]) begin
                    child_valid[i] <= 1'b1;
                    mbox[i]        <= head_data;
                end else if (child_ack[i]) begin
                    child_valid[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            drop_count <= '0;
        end else if (drop && (drop_count != 8'hFF)) begin
            drop_count <= drop_count + 8'd1;
        end
    end

    for (genvar g = 0; g < NUM_CORES; g++) begin : g_flat
        assign child_data[g*DATA_W +: DATA_W] = mbox[g];
    end

endmodule

// File: tb/tb_child_dispatch.sv
// tb/tb_child_dispatch.sv - directed self-checking bench for child_dispatch
module tb_child_dispatch;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;

    logic          wr_en = 1'b0;
    logic [4:0]    wr_addr = '0;
    logic [31:0]   wr_data = '0;
    logic          full;
    logic          all_taken;
    logic [7:0]    drop_count;
    logic [991:0]  child_data;
    logic [30:0]   child_valid;
    logic [30:0]   child_ack = '0;

    logic          wr_en_b = 1'b0;
    logic [4:0]    wr_addr_b = '0;
    logic [31:0]   wr_data_b = '0;
    logic          full_b;
    logic          all_taken_b;
    logic [7:0]    drop_count_b;
    logic [959:0]  child_data_b;
    logic [29:0]   child_valid_b;
    logic [29:0]   child_ack_b = '0;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    child_dispatch u_dut (
        .Clk           (clk),
        .Reset         (rst_n),
        .par_wr_en     (wr_en),
        .par_wr_addr   (wr_addr),
        .par_wr_data   (wr_data),
        .par_full      (full),
        .par_all_taken (all_taken),
        .drop_count    (drop_count),
        .child_data    (child_data),
        .child_valid   (child_valid),
        .child_ack     (child_ack)
    );

    child_dispatch #(.NUM_CORES(30)) u_dut30 (
        .Clk           (clk),
        .Reset         (rst_n),
        .par_wr_en     (wr_en_b),
        .par_wr_addr   (wr_addr_b),
        .par_wr_data   (wr_data_b),
        .par_full      (full_b),
        .par_all_taken (all_taken_b),
        .drop_count    (drop_count_b),
        .child_data    (child_data_b),
        .child_valid   (child_valid_b),
        .child_ack     (child_ack_b)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mbox(input int i);
        return child_data[i*32 +: 32];
    endfunction

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        @(posedge clk); @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic ack_mask(input logic [30:0] m);
        child_ack = m;
        @(negedge clk);
        child_ack = '0;
    endtask

    initial begin
        // reset state
        idle(2);
        check("rst_valid", child_valid, 0);
        check("rst_all_taken", all_taken, 1);
        check("rst_drop", drop_count, 0);
        check("rst_full", full, 0);
        check("rst_data5", mbox(5), 0);
        rst_n = 1'b1;
        idle(1);

        // unicast latency, ack, retention
        wr(5'd5, 32'hDEADBEEF);
        check("uni_n1_valid", child_valid, 0);
        idle(1);
        check("uni_valid", child_valid, 31'h1 << 5);
        check("uni_data", mbox(5), 32'hDEADBEEF);
        check("uni_busy", all_taken, 0);
        ack_mask(31'h1 << 5);
        check("uni_ack_valid", child_valid, 0);
        check("uni_ack_taken", all_taken, 1);
        check("uni_retain", mbox(5), 32'hDEADBEEF);

        // head-of-line blocking
        wr(5'd3, 32'h1);
        wr(5'd3, 32'h2);
        wr(5'd7, 32'h3);
        idle(2);
        check("hol_data3", mbox(3), 32'h1);
        check("hol_valid", child_valid, 31'h1 << 3);
        ack_mask(31'h1 << 3);
        check("hol_ack", child_valid, 0);
        idle(1);
        check("hol_data3b", mbox(3), 32'h2);
        check("hol_valid_b", child_valid, 31'h1 << 3);
        idle(1);
        check("hol_data7", mbox(7), 32'h3);
        check("hol_valid_c", child_valid, (31'h1 << 3) | (31'h1 << 7));
        ack_mask((31'h1 << 3) | (31'h1 << 7));
        check("hol_taken", all_taken, 1);

        // broadcast waits for every mailbox to drain
        wr(5'd10, 32'h10);
        idle(1);
        wr(5'd31, 32'hCAFE0000);
        idle(3);
        check("bc_stall_valid", child_valid, 31'h1 << 10);
        check("bc_stall_data0", mbox(0), 0);
        check("bc_stall_data10", mbox(10), 32'h10);
        ack_mask(31'h1 << 10);
        check("bc_ack", child_valid, 0);
        idle(1);
        check("bc_valid", child_valid, 31'h7FFF_FFFF);
        check("bc_data0", mbox(0), 32'hCAFE0000);
        check("bc_data10", mbox(10), 32'hCAFE0000);
        check("bc_data30", mbox(30), 32'hCAFE0000);
        ack_mask('1);
        check("bc_taken", all_taken, 1);

        // overflow: 1 loads, 4 queue, 1 drops
        wr_en = 1'b1; wr_addr = 5'd0;
        for (int k = 1; k <= 6; k++) begin
            wr_data = k;
            @(posedge clk); @(negedge clk);
        end
        wr_en = 1'b0;
        check("ovf_full", full, 1);
        check("ovf_drop", drop_count, 1);
        check("ovf_data0", mbox(0), 1);
        check("ovf_valid", child_valid, 31'h1);
        // write during the ack cycle and during the following pop cycle
        child_ack[0] = 1'b1; wr_en = 1'b1; wr_data = 32'h77;
        @(posedge clk); @(negedge clk);
        child_ack = '0;
        @(posedge clk); @(negedge clk);
        wr_en = 1'b0;
        check("ovf_pop_drop", drop_count, 3);
        check("ovf_pop_full", full, 0);
        check("ovf_pop_valid", child_valid, 31'h1);
        for (int k = 2; k <= 5; k++) begin
            check("ovf_drain_data", mbox(0), k);
            ack_mask(31'h1);
            idle(1);
        end
        check("ovf_drain_valid", child_valid, 0);
        check("ovf_drain_taken", all_taken, 1);
        check("ovf_retain", mbox(0), 5);

        // bad address on a 30-core instance, broadcast coverage, saturation
        wr_en_b = 1'b1; wr_addr_b = 5'd30; wr_data_b = 32'h55;
        @(posedge clk); @(negedge clk);
        wr_en_b = 1'b0;
        idle(2);
        check("bad_drop", drop_count_b, 1);
        check("bad_valid", child_valid_b, 0);
        check("bad_taken", all_taken_b, 1);
        wr_en_b = 1'b1; wr_addr_b = 5'd31; wr_data_b = 32'hABCD0001;
        @(posedge clk); @(negedge clk);
        wr_en_b = 1'b0;
        idle(1);
        check("b30_valid", child_valid_b, 30'h3FFF_FFFF);
        check("b30_data29", child_data_b[29*32 +: 32], 32'hABCD0001);
        check("b30_drop", drop_count_b, 1);
        wr_en_b = 1'b1; wr_addr_b = 5'd30;
        repeat (300) @(negedge clk);
        wr_en_b = 1'b0;
        check("sat_drop", drop_count_b, 255);

        // reset in the middle of traffic
        wr(5'd2, 32'hA);
        idle(1);
        wr(5'd2, 32'hB);
        wr(5'd2, 32'hC);
        wr(5'd2, 32'hD);
        check("mid_pre_valid", child_valid, 31'h1 << 2);
        check("mid_pre_drop", drop_count, 3);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", child_valid, 0);
        check("mid_rst_taken", all_taken, 1);
        check("mid_rst_drop", drop_count, 0);
        check("mid_rst_data2", mbox(2), 0);
        idle(2);
        rst_n = 1'b1;
        idle(3);
        check("mid_post_valid", child_valid, 0);
        check("mid_post_taken", all_taken, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
